// File: rtl/mte_block_loader.sv
// mte_block_loader: byte-serial front end for the MTE core.
// Assembles key and data frames (first byte at the MSB) into N-bit registers,
// then presents each data block to MTE with a one-cycle start strobe and waits
// for MTE to report completion.
// Optional build macro MTE_LOADER_TIMEOUT_EN: bounds WAIT to TIMEOUT cycles and
// raises err_timeout when that bound expires.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | no frame in progress; first accepted byte latches frame type/mode
// FILL  | collecting bytes of the current frame into the assembly register
// ISSUE | one cycle, blk_start=1, block presented to MTE
// WAIT  | waiting for blk_done (or timeout when compiled in)
module mte_block_loader #(
   parameter int N       = 256,
   parameter int TIMEOUT = 64
) (
   input  logic         clock,
   input  logic         reset_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [7:0]   in_data,
   input  logic         in_last,
   input  logic         in_is_key,
   input  logic         in_sel,
   output logic [N-1:0] blk_key,
   output logic [N-1:0] blk_data,
   output logic         blk_sel,
   output logic         blk_start,
   input  logic         blk_done,
   output logic         busy,
   output logic         key_loaded,
   output logic         err_timeout
);

   localparam int NB = N / 8;
   localparam int CW = (NB > 1) ? $clog2(NB) : 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FILL  = 2'd1,
      S_ISSUE = 2'd2,
      S_WAIT  = 2'd3
   } state_t;

   state_t        state;
   state_t        state_nx;
   logic [CW-1:0] cnt;
   logic [N-1:0]  asm_q;
   logic [N-1:0]  asm_d;
   logic          is_key_q;
   logic          sel_q;
   logic          acc;
   logic          frame_end;
   logic          cur_key;
   logic          cur_sel;
   logic          tmo;

   // Frame type and mode come from the live inputs on the first byte only;
   // afterwards the latched copies are used so mid-frame changes are ignored.
   assign acc       = in_valid && ((state == S_IDLE) || (state == S_FILL));
   assign cur_key   = (state == S_IDLE) ? in_is_key : is_key_q;
   assign cur_sel   = (state == S_IDLE) ? in_sel    : sel_q;
   assign frame_end = acc && (in_last || (cnt == CW'(NB - 1)));

`ifdef MTE_LOADER_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT + 1);
   logic [TW-1:0] tcnt;
   logic          err_q;

   // blk_done wins over an expiring timer on the same cycle.
   assign tmo         = (state == S_WAIT) && !blk_done && (tcnt == TW'(TIMEOUT - 1));
   assign err_timeout = err_q;

   // WAIT cycle counter; held at zero outside WAIT so it starts clean on entry.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         tcnt  <= '0;
         err_q <= 1'b0;
      end else begin
         tcnt  <= (state == S_WAIT) ? tcnt + 1'b1 : '0;
         err_q <= tmo;
      end
   end
`else
   assign tmo         = 1'b0;
   // Constant 0; TIMEOUT only has meaning in the timeout build.
   assign err_timeout = (TIMEOUT < 0);
`endif

   // Next assembly value: cleared on a frame's first byte, byte k lands at the k-th byte from the top.
   always_comb begin
      asm_d = (state == S_IDLE) ? '0 : asm_q;
      for (int k = 0; k < NB; k++) begin
         if (cnt == CW'(k)) asm_d[N-1-8*k -: 8] = in_data;
      end
   end

   // State register.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) state <= S_IDLE;
      else          state <= state_nx;
   end

   // Next-state and handshake/strobe outputs.
   always_comb begin
      state_nx  = state;
      in_ready  = 1'b0;
      blk_start = 1'b0;
      busy      = 1'b0;
      case (state)
         S_IDLE: begin
            in_ready = 1'b1;
            if (frame_end)  state_nx = cur_key ? S_IDLE : S_ISSUE;
            else if (acc)   state_nx = S_FILL;
         end
         S_FILL: begin
            in_ready = 1'b1;
            if (frame_end)  state_nx = cur_key ? S_IDLE : S_ISSUE;
         end
         S_ISSUE: begin
            blk_start = 1'b1;
            busy      = 1'b1;
            state_nx  = S_WAIT;
         end
         S_WAIT: begin
            busy = 1'b1;
            if (blk_done || tmo) state_nx = S_IDLE;
         end
         default: state_nx = S_IDLE;
      endcase
   end

   // Byte counter, assembly register and the MTE-facing registers.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         cnt        <= '0;
         asm_q      <= '0;
         is_key_q   <= 1'b0;
         sel_q      <= 1'b0;
         blk_key    <= '0;
         blk_data   <= '0;
         blk_sel    <= 1'b0;
         key_loaded <= 1'b0;
      end else if (acc) begin
         if (state == S_IDLE) begin
            is_key_q <= in_is_key;
            sel_q    <= in_sel;
         end
         asm_q <= asm_d;
         cnt   <= frame_end ? '0 : cnt + 1'b1;
         if (frame_end) begin
            if (cur_key) begin
               blk_key    <= asm_d;
               key_loaded <= 1'b1;
            end else begin
               blk_data <= asm_d;
               blk_sel  <= cur_sel;
            end
         end
      end
   end

endmodule

// File: tb/tb_mte_block_loader.sv
// Testbench for mte_block_loader: frame table plus hand-written corner cases,
// with a scoreboard of expected blocks checked whenever blk_start fires.
module tb_mte_block_loader;

   localparam int N       = 256;
   localparam int NB      = N / 8;
   localparam int TIMEOUT = 64;

   logic         clock;
   logic         reset_n;
   logic         in_valid;
   logic         in_ready;
   logic [7:0]   in_data;
   logic         in_last;
   logic         in_is_key;
   logic         in_sel;
   logic [N-1:0] blk_key;
   logic [N-1:0] blk_data;
   logic         blk_sel;
   logic         blk_start;
   logic         blk_done;
   logic         busy;
   logic         key_loaded;
   logic         err_timeout;

   mte_block_loader #(.N(N), .TIMEOUT(TIMEOUT)) dut (
      .clock       (clock),
      .reset_n     (reset_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_data     (in_data),
      .in_last     (in_last),
      .in_is_key   (in_is_key),
      .in_sel      (in_sel),
      .blk_key     (blk_key),
      .blk_data    (blk_data),
      .blk_sel     (blk_sel),
      .blk_start   (blk_start),
      .blk_done    (blk_done),
      .busy        (busy),
      .key_loaded  (key_loaded),
      .err_timeout (err_timeout)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      bit         is_key;
      bit         sel;
      int         len;
      bit         last;
      logic [7:0] base;
      logic [7:0] step;
      bit         flip;
      int         delay;
   } vec_t;

   typedef struct {
      logic [N-1:0] data;
      logic         sel;
      logic [N-1:0] key;
   } exp_t;

   exp_t         sbq[$];
   int           checks  = 0;
   int           errors  = 0;
   int           starts  = 0;
   int           n_data  = 0;
   logic [N-1:0] key_model = '0;

   task automatic chkw(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   task automatic chki(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Reference block: bytes shifted in MSB-first, unwritten low bytes zero.
   function automatic logic [N-1:0] model(input logic [7:0] base, input logic [7:0] step, input int len);
      logic [N-1:0] v;
      logic [7:0]   b;
      v = '0;
      b = base;
      for (int k = 0; k < len; k++) begin
         v = {v[N-9:0], b};
         b = b + step;
      end
      v = v << (8 * (NB - len));
      return v;
   endfunction

   // Scoreboard: every start strobe must match the oldest expected block.
   always @(negedge clock) begin : mon
      exp_t e;
      if (reset_n && blk_start) begin
         starts++;
         if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_start: got strobe expected none");
         end else begin
            e = sbq.pop_front();
            chkw("start_data", blk_data, e.data);
            chk1("start_sel", blk_sel, e.sel);
            chkw("start_key", blk_key, e.key);
         end
      end
   end

   // Drives one byte and returns 1 ns after the accepting edge.
   task automatic send_byte(input logic [7:0] d, input logic last, input logic ik, input logic sl);
      int guard;
      guard     = 0;
      in_valid  = 1'b1;
      in_data   = d;
      in_last   = last;
      in_is_key = ik;
      in_sel    = sl;
      while (!in_ready && guard < 200) begin
         @(posedge clock);
         #1;
         guard++;
      end
      if (guard >= 200) begin
         checks++;
         errors++;
         $display("FAIL ready_timeout: got in_ready=0 expected 1 within 200 cycles");
      end
      @(posedge clock);
      #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic send_frame(input vec_t v);
      logic [7:0] b;
      b = v.base;
      for (int k = 0; k < v.len; k++) begin
         send_byte(b, (k == v.len - 1) ? v.last : 1'b0,
                   (v.flip && k > 0) ? ~v.is_key : v.is_key,
                   (v.flip && k > 0) ? ~v.sel    : v.sel);
         b = b + v.step;
      end
   endtask

   // Called right after ISSUE is entered: checks strobe width, then completes with blk_done.
   task automatic finish_block(input int delay, input logic [N-1:0] exp);
      @(posedge clock);
      #1;
      chk1("start_width", blk_start, 1'b0);
      chk1("wait_busy", busy, 1'b1);
      for (int i = 1; i < delay; i++) begin
         @(posedge clock);
         #1;
      end
      blk_done = 1'b1;
      @(posedge clock);
      #1;
      blk_done = 1'b0;
      chk1("done_ready", in_ready, 1'b1);
      chk1("done_busy", busy, 1'b0);
      chkw("done_data_kept", blk_data, exp);
   endtask

   task automatic run_vec(input vec_t v);
      logic [N-1:0] exp;
      exp = model(v.base, v.step, v.len);
      if (!v.is_key) begin
         sbq.push_back('{data: exp, sel: v.sel, key: key_model});
         n_data++;
      end
      send_frame(v);
      if (v.is_key) begin
         key_model = exp;
         chkw("key_value", blk_key, exp);
         chk1("key_loaded", key_loaded, 1'b1);
         chk1("key_in_ready", in_ready, 1'b1);
      end else begin
         chk1("issue_start", blk_start, 1'b1);
         chk1("issue_ready", in_ready, 1'b0);
         chk1("issue_busy", busy, 1'b1);
         finish_block(v.delay, exp);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no finish expected finish within 1 ms");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t         vecs[9];
      vec_t         w;
      logic [N-1:0] lit;
      logic [N-1:0] e1;
      int           n;
      int           bad;

      vecs[0] = '{is_key: 1, sel: 0, len: 32, last: 1, base: 8'h01, step: 8'h01, flip: 0, delay: 0};
      vecs[1] = '{is_key: 0, sel: 1, len: 32, last: 1, base: 8'hFE, step: 8'h00, flip: 0, delay: 5};
      vecs[2] = '{is_key: 0, sel: 0, len: 2,  last: 1, base: 8'hAB, step: 8'h22, flip: 0, delay: 1};
      vecs[3] = '{is_key: 0, sel: 1, len: 1,  last: 1, base: 8'h5A, step: 8'h00, flip: 0, delay: 1};
      vecs[4] = '{is_key: 1, sel: 0, len: 3,  last: 1, base: 8'h10, step: 8'h11, flip: 1, delay: 0};
      vecs[5] = '{is_key: 0, sel: 0, len: 32, last: 0, base: 8'h80, step: 8'h03, flip: 1, delay: 3};
      vecs[6] = '{is_key: 1, sel: 0, len: 32, last: 0, base: 8'hC0, step: 8'h01, flip: 0, delay: 0};
      vecs[7] = '{is_key: 1, sel: 1, len: 2,  last: 1, base: 8'h9A, step: 8'h01, flip: 0, delay: 0};
      vecs[8] = '{is_key: 0, sel: 1, len: 5,  last: 1, base: 8'h31, step: 8'h07, flip: 1, delay: 2};

      reset_n   = 1'b0;
      in_valid  = 1'b0;
      in_data   = 8'h00;
      in_last   = 1'b0;
      in_is_key = 1'b0;
      in_sel    = 1'b0;
      blk_done  = 1'b0;
      repeat (2) @(negedge clock);
      chk1("rst_in_ready", in_ready, 1'b1);
      chkw("rst_blk_key", blk_key, '0);
      chkw("rst_blk_data", blk_data, '0);
      chk1("rst_blk_sel", blk_sel, 1'b0);
      chk1("rst_blk_start", blk_start, 1'b0);
      chk1("rst_busy", busy, 1'b0);
      chk1("rst_key_loaded", key_loaded, 1'b0);
      chk1("rst_err_timeout", err_timeout, 1'b0);
      reset_n = 1'b1;
      @(posedge clock);
      #1;

      for (int i = 0; i < 9; i++) begin
         run_vec(vecs[i]);
         if (i == 0) begin
            chki("key_msw", blk_key[N-1 -: 32], 32'h01020304);
            chki("key_lsw", blk_key[31:0], 32'h1D1E1F20);
         end
         if (i == 2) begin
            lit = '0;
            lit[N-1 -: 16] = 16'hABCD;
            chkw("short_literal", blk_data, lit);
            chk1("short_sel", blk_sel, 1'b0);
         end
      end

      // blk_done held high outside WAIT must not shorten the cycle.
      blk_done = 1'b1;
      @(posedge clock);
      #1;
      chk1("done_idle_ready", in_ready, 1'b1);
      chk1("done_idle_busy", busy, 1'b0);
      w  = '{is_key: 0, sel: 1, len: 2, last: 1, base: 8'h44, step: 8'h01, flip: 0, delay: 1};
      e1 = model(w.base, w.step, w.len);
      sbq.push_back('{data: e1, sel: 1'b1, key: key_model});
      n_data++;
      send_frame(w);
      blk_done = 1'b0;
      chk1("done_fill_issue", blk_start, 1'b1);
      finish_block(2, e1);

      // Backpressure: a key byte with in_last offered during ISSUE/WAIT is never taken.
      w  = '{is_key: 0, sel: 1, len: 1, last: 1, base: 8'h11, step: 8'h00, flip: 0, delay: 1};
      e1 = model(w.base, w.step, w.len);
      sbq.push_back('{data: e1, sel: 1'b1, key: key_model});
      n_data++;
      send_frame(w);
      in_valid  = 1'b1;
      in_data   = 8'h77;
      in_last   = 1'b1;
      in_is_key = 1'b1;
      bad = 0;
      for (int i = 0; i < 4; i++) begin
         if (in_ready) bad++;
         @(posedge clock);
         #1;
      end
      chki("bp_ready_low", bad, 0);
      in_valid = 1'b0;
      in_last  = 1'b0;
      blk_done = 1'b1;
      @(posedge clock);
      #1;
      blk_done = 1'b0;
      chkw("bp_key_unchanged", blk_key, key_model);
      run_vec('{is_key: 0, sel: 0, len: 3, last: 1, base: 8'h21, step: 8'h11, flip: 0, delay: 1});

      // Long WAIT: timeout build must give up after TIMEOUT cycles, default build holds.
      w  = '{is_key: 0, sel: 0, len: 1, last: 1, base: 8'hE7, step: 8'h00, flip: 0, delay: 1};
      e1 = model(w.base, w.step, w.len);
      sbq.push_back('{data: e1, sel: 1'b0, key: key_model});
      n_data++;
      send_frame(w);
      @(posedge clock);
      #1;
`ifdef MTE_LOADER_TIMEOUT_EN
      n = 0;
      while (!err_timeout && n < 200) begin
         @(posedge clock);
         #1;
         n++;
      end
      chki("timeout_cycles", n, TIMEOUT);
      chk1("timeout_ready", in_ready, 1'b1);
      chk1("timeout_busy", busy, 1'b0);
      chkw("timeout_data_kept", blk_data, e1);
      @(posedge clock);
      #1;
      chk1("timeout_pulse_width", err_timeout, 1'b0);
`else
      n   = 0;
      bad = 0;
      repeat (80) begin
         @(posedge clock);
         #1;
         n++;
         if (err_timeout || !busy) bad++;
      end
      chki("hold_wait", bad, 0);
      blk_done = 1'b1;
      @(posedge clock);
      #1;
      blk_done = 1'b0;
      chk1("hold_release_busy", busy, 1'b0);
`endif

      // Reset mid-FILL with a key loaded: immediate clear, then a clean full frame.
      w = '{is_key: 0, sel: 1, len: 10, last: 0, base: 8'h60, step: 8'h01, flip: 0, delay: 0};
      send_frame(w);
      #2;
      reset_n = 1'b0;
      #1;
      chkw("rstmid_key", blk_key, '0);
      chk1("rstmid_key_loaded", key_loaded, 1'b0);
      chk1("rstmid_ready", in_ready, 1'b1);
      chk1("rstmid_busy", busy, 1'b0);
      chkw("rstmid_data", blk_data, '0);
      key_model = '0;
      @(negedge clock);
      reset_n = 1'b1;
      @(posedge clock);
      #1;
      run_vec('{is_key: 0, sel: 1, len: 32, last: 1, base: 8'h07, step: 8'h05, flip: 0, delay: 2});

      repeat (3) @(posedge clock);
      #1;
      chki("sb_empty", sbq.size(), 0);
      chki("start_count", starts, n_data);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
